mem_access_ctrl: RTL and testbench

Controller for the MEM stage of the 5-stage MIPS pipeline. It sequences every load and store onto a variable-latency data-memory bus with a req/ack handshake. It stalls the pipeline while an access is outstanding and produces byte enables, store-data lane steering and load-data extraction with sign or zero extension. It drives the MEM/WB fields (destination register, write flag, write data) that the writeback path consumes.

---
 rtl/mips_mem_pkg.sv | 41 ++++
 rtl/mem_access_ctrl_if.sv | 18 +
 rtl/mem_lane_align.sv | 45 ++++
 rtl/mem_access_ctrl.sv | 123 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage access controller: op encodings,
// FSM states, byte-enable constants and small op classifiers.
package mips_mem_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LB  = 4'd1,
    OP_LBU = 4'd2,
    OP_LH  = 4'd3,
    OP_LHU = 4'd4,
    OP_LW  = 4'd5,
    OP_SB  = 4'd6,
    OP_SH  = 4'd7,
    OP_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic is_store(mem_op_e op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  // Halfwords need addr[0]==0, words need addr[1:0]==0.
  function automatic logic is_misaligned(mem_op_e op, logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return |off;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus: req/ack handshake, word address, byte enables, data.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
                  input  bus_ack, bus_rdata);
  modport slave  (input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
                  output bus_ack, bus_rdata);
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables / replicated store data, and
// load byte/halfword extraction with sign or zero extension.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_data,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] rd_ext
);
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = rd_data[{off, 3'b000} +: 8];
  assign rd_half = off[1] ? rd_data[31:16] : rd_data[15:0];

  always_comb begin
    be         = BE_NONE;
    lane_wdata = '0;
    rd_ext     = '0;
    case (op)
      OP_LB:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU: rd_ext = {24'b0, rd_byte};
      OP_LH:  rd_ext = {{16{rd_half[15]}}, rd_half};
      OP_LHU: rd_ext = {16'b0, rd_half};
      OP_LW:  rd_ext = rd_data;
      OP_SB: begin
        be         = BE_BYTE << off;
        lane_wdata = {4{st_data[7:0]}};
      end
      OP_SH: begin
        be         = BE_HALF << {off[1], 1'b0};
        lane_wdata = {2{st_data[15:0]}};
      end
      OP_SW: begin
        be         = BE_WORD;
        lane_wdata = st_data;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: sequences loads/stores onto the req/ack data bus,
// stalls the pipeline meanwhile and drives the MEM/WB fields.
// Optional: MEM_ALIGN_CHECK_EN traps misaligned halfword/word accesses.
module mem_access_ctrl
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             mem_op,
  input  logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      store_data,
  input  logic [4:0]             dest_addr,
  input  logic                   write_or_not,
  input  logic [DATA_W-1:0]      wdata,
  mem_access_ctrl_if.master      bus,
  output logic                   stall_req,
  output logic [4:0]             dest_addr_output,
  output logic                   write_or_not_output,
  output logic [DATA_W-1:0]      wdata_output,
  output logic                   exc_misaligned
);
  state_e            state;
  mem_op_e           op_in, op_q;
  logic              is_mem, mis, start;
  logic              bus_req_q, wr_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] sdata_q, load_q;
  logic [4:0]        dest_q;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wd, rd_ext;

  // Unknown encodings behave as NOP.
  assign op_in  = mem_op_e'(mem_op);
  assign is_mem = op_in inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
                                OP_SB, OP_SH, OP_SW};
`ifdef MEM_ALIGN_CHECK_EN
  assign mis = is_mem && is_misaligned(op_in, mem_addr[1:0]);
`else
  assign mis = 1'b0;
`endif
  assign start = (state == S_IDLE) && is_mem && !mis;

  mem_lane_align u_align (
    .op        (op_q),
    .off       (off_q),
    .st_data   (sdata_q),
    .rd_data   (bus.bus_rdata),
    .be        (lane_be),
    .lane_wdata(lane_wd),
    .rd_ext    (rd_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bus_req_q <= 1'b0;
      op_q      <= OP_NOP;
      off_q     <= '0;
      addr_q    <= '0;
      sdata_q   <= '0;
      dest_q    <= '0;
      wr_q      <= 1'b0;
      load_q    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_q      <= op_in;
          off_q     <= mem_addr[1:0];
          addr_q    <= {mem_addr[ADDR_W-1:2], 2'b00};
          sdata_q   <= store_data;
          dest_q    <= dest_addr;
          wr_q      <= write_or_not;
          load_q    <= '0;
          bus_req_q <= 1'b1;
          state     <= S_BUSY;
        end
        S_BUSY: if (bus.bus_ack) begin
          bus_req_q <= 1'b0;
          if (!is_store(op_q)) load_q <= rd_ext;
          state     <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus fields are only meaningful while the request is up.
  assign bus.bus_req   = !rst && bus_req_q;
  assign bus.bus_we    = bus.bus_req && is_store(op_q);
  assign bus.bus_addr  = bus.bus_req ? addr_q  : '0;
  assign bus.bus_be    = bus.bus_req ? lane_be : BE_NONE;
  assign bus.bus_wdata = bus.bus_req ? lane_wd : '0;

  assign stall_req      = !rst && (start || state == S_BUSY);
  assign exc_misaligned = !rst && (state == S_IDLE) && mis;

  // A memory op in IDLE and every BUSY cycle present a bubble to MEM/WB.
  always_comb begin
    dest_addr_output    = '0;
    write_or_not_output = 1'b0;
    wdata_output        = '0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          dest_addr_output    = dest_addr;
          write_or_not_output = write_or_not && !is_mem;
          wdata_output        = wdata;
        end
        S_DONE: begin
          dest_addr_output    = dest_q;
          write_or_not_output = wr_q && !is_store(op_q);
          wdata_output        = load_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl; expectations are hand-computed.
// Builds with or without MEM_ALIGN_CHECK_EN.
module tb_mem_access_ctrl;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr, store_data, wdata;
  logic [4:0]  dest_addr;
  logic        write_or_not;
  logic        stall_req, write_or_not_output, exc_misaligned;
  logic [4:0]  dest_addr_output;
  logic [31:0] wdata_output;
  int          checks = 0;
  int          errors = 0;

  mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_op             (mem_op),
    .mem_addr           (mem_addr),
    .store_data         (store_data),
    .dest_addr          (dest_addr),
    .write_or_not       (write_or_not),
    .wdata              (wdata),
    .bus                (bus_if.master),
    .stall_req          (stall_req),
    .dest_addr_output   (dest_addr_output),
    .write_or_not_output(write_or_not_output),
    .wdata_output       (wdata_output),
    .exc_misaligned     (exc_misaligned)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access: IDLE cycle, waits+1 BUSY cycles (ack on the last), DONE.
  task automatic access(input string tag, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [31:0] rd, input int waits,
                        input logic [31:0] ebaddr, input logic [3:0] ebe,
                        input logic [31:0] ebw, input logic ewe,
                        input logic ewr, input logic [31:0] eout);
    int stalls;
    mem_op = op; mem_addr = addr; store_data = sd;
    dest_addr = 5'd9; write_or_not = 1'b1; wdata = 32'hDEAD_BEEF;
    #1;
    chk({tag, " idle stall"}, stall_req, 1'b1);
    chk({tag, " idle req"}, bus_if.bus_req, 1'b0);
    chk({tag, " idle wr"}, write_or_not_output, 1'b0);
    stalls = stall_req ? 1 : 0;
    for (int i = 0; i <= waits; i++) begin
      tick();
      if (i == waits) begin
        bus_if.bus_ack = 1'b1;
        bus_if.bus_rdata = rd;
      end else begin
        bus_if.bus_rdata = 32'h5A5A_5A5A;
      end
      #1;
      chk({tag, " req"}, bus_if.bus_req, 1'b1);
      chk({tag, " addr"}, bus_if.bus_addr, ebaddr);
      chk({tag, " be"}, bus_if.bus_be, ebe);
      chk({tag, " we"}, bus_if.bus_we, ewe);
      chk({tag, " bwdata"}, bus_if.bus_wdata, ebw);
      if (stall_req) stalls++;
    end
    tick();
    bus_if.bus_ack = 1'b0;
    #1;
    chk({tag, " done stall"}, stall_req, 1'b0);
    chk({tag, " done req"}, bus_if.bus_req, 1'b0);
    chk({tag, " done wr"}, write_or_not_output, ewr);
    chk({tag, " done dest"}, dest_addr_output, 5'd9);
    if (ewr) chk({tag, " done wdata"}, wdata_output, eout);
    chk({tag, " stall cycles"}, stalls, waits + 2);
    mem_op = OP_NOP;
    tick();
  endtask

  initial begin
    rst = 1'b1; mem_op = OP_NOP; mem_addr = 32'h0; store_data = 32'h0;
    dest_addr = 5'd3; write_or_not = 1'b1; wdata = 32'h55;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    tick(); tick();
    // Reset state: everything zero even with live inputs.
    chk("rst stall", stall_req, 1'b0);
    chk("rst req", bus_if.bus_req, 1'b0);
    chk("rst wr", write_or_not_output, 1'b0);
    chk("rst wdata", wdata_output, 32'h0);
    chk("rst dest", dest_addr_output, 5'd0);
    chk("rst exc", exc_misaligned, 1'b0);
    rst = 1'b0;

    // NOP passthrough.
    dest_addr = 5'd5; write_or_not = 1'b1; wdata = 32'h1234;
    #1;
    chk("nop dest", dest_addr_output, 5'd5);
    chk("nop wr", write_or_not_output, 1'b1);
    chk("nop wdata", wdata_output, 32'h1234);
    chk("nop stall", stall_req, 1'b0);
    tick();
    chk("nop req", bus_if.bus_req, 1'b0);

    access("lb", OP_LB, 32'h1003, 32'h0, 32'h80FF_FF00, 2,
           32'h1000, 4'b0000, 32'h0, 1'b0, 1'b1, 32'hFFFF_FF80);
    access("lhu", OP_LHU, 32'h2002, 32'h0, 32'h8001_0000, 0,
           32'h2000, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h0000_8001);
    access("sh", OP_SH, 32'h3002, 32'h0000_ABCD, 32'h0, 0,
           32'h3000, 4'b1100, 32'hABCD_ABCD, 1'b1, 1'b0, 32'h0);
    access("sb", OP_SB, 32'h6001, 32'h1234_5678, 32'h0, 1,
           32'h6000, 4'b0010, 32'h7878_7878, 1'b1, 1'b0, 32'h0);
    access("lh", OP_LH, 32'h7000, 32'h0, 32'h1234_F00D, 0,
           32'h7000, 4'b0000, 32'h0, 1'b0, 1'b1, 32'hFFFF_F00D);
    access("lbu", OP_LBU, 32'h7002, 32'h0, 32'h00C3_0000, 0,
           32'h7000, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h0000_00C3);
    access("sw", OP_SW, 32'h8004, 32'hCAFE_0001, 32'h0, 0,
           32'h8004, 4'b1111, 32'hCAFE_0001, 1'b1, 1'b0, 32'h0);

    // Reset while BUSY, then a late ack in IDLE.
    mem_op = OP_LW; mem_addr = 32'h5000;
    tick();
    chk("rstbusy req", bus_if.bus_req, 1'b1);
    rst = 1'b1;
    tick();
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h1111_2222;
    #1;
    chk("rstbusy req after", bus_if.bus_req, 1'b0);
    chk("rstbusy stall", stall_req, 1'b0);
    chk("rstbusy wdata", wdata_output, 32'h0);
    rst = 1'b0; mem_op = OP_NOP; dest_addr = 5'd3; write_or_not = 1'b1; wdata = 32'h77;
    #1;
    chk("late ack stall", stall_req, 1'b0);
    tick();
    bus_if.bus_ack = 1'b0;
    #1;
    chk("late ack req", bus_if.bus_req, 1'b0);
    chk("late ack idle wdata", wdata_output, 32'h77);
    chk("late ack idle wr", write_or_not_output, 1'b1);
    tick();

    // Misaligned word load.
`ifdef MEM_ALIGN_CHECK_EN
    mem_op = OP_LW; mem_addr = 32'h4001; write_or_not = 1'b1;
    #1;
    chk("mis exc", exc_misaligned, 1'b1);
    chk("mis stall", stall_req, 1'b0);
    chk("mis wr", write_or_not_output, 1'b0);
    tick();
    chk("mis req", bus_if.bus_req, 1'b0);
    mem_op = OP_NOP;
    #1;
    chk("mis exc drop", exc_misaligned, 1'b0);
    tick();
    chk("mis req after", bus_if.bus_req, 1'b0);
`else
    access("lw mis", OP_LW, 32'h4001, 32'h0, 32'hCAFE_F00D, 0,
           32'h4000, 4'b0000, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D);
    chk("mis exc tied", exc_misaligned, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
